// File: rtl/memory_game_pkg.sv
// rtl/memory_game_pkg.sv - shared card-memory constants, shuffle FSM states and LFSR helpers
//
// Contents:
//   CARD_W, ADDR_W, NUM_CARDS          card memory geometry
//   CARD_REMOVED, CARD_FACEDOWN        bit indices within a card word
//   LFSR_TAPS                          Galois tap mask for the 8-bit shuffle LFSR
//   shuffle_state_t                    board_shuffle_ctrl sequencer states
//   lfsr8_next()                       one right-shift Galois step
//   face_down_card()                   builds a fresh {removed=0, face-down=1, value} word
package memory_game_pkg;

  localparam int CARD_W        = 6;
  localparam int ADDR_W        = 4;
  localparam int NUM_CARDS     = 16;
  localparam int CARD_REMOVED  = 5;
  localparam int CARD_FACEDOWN = 4;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD_I,
    RD_J,
    CAP,
    WR_I,
    WR_J,
    FIN
  } shuffle_state_t;

  // A non-zero state never maps to zero, so the sequence cannot lock up.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [CARD_W-1:0] face_down_card(input logic [3:0] value);
    logic [CARD_W-1:0] c;
    c                = '0;
    c[CARD_FACEDOWN] = 1'b1;
    c[3:0]           = value;
    return c;
  endfunction

endpackage

// File: rtl/board_shuffle_ctrl_if.sv
// rtl/board_shuffle_ctrl_if.sv - single-port card memory bus (write enable, address, write/read data)
//
// Signals:
//   we    write enable, driven by the requester
//   addr  card address, driven by the requester
//   din   write data, driven by the requester
//   dout  read data, driven by the responder (RAM: one cycle after addr)
// Modports:
//   master  requester side (gameplay towards the controller, controller towards the RAM)
//   slave   responder side
interface board_shuffle_ctrl_if;
  import memory_game_pkg::*;

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [CARD_W-1:0] din;
  logic [CARD_W-1:0] dout;

  modport master (output we, output addr, output din, input dout);
  modport slave  (input we, input addr, input din, output dout);

endinterface

// File: rtl/lfsr8_galois.sv
// rtl/lfsr8_galois.sv - 8-bit right-shift Galois LFSR with seed load and zero-seed substitution
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (value returns to INIT_VAL)
//   i_load   load i_seed (or INIT_VAL when i_seed is zero); has priority over i_step
//   i_seed   seed value
//   i_step   advance one step
//   o_value  current LFSR state
// INIT_VAL must be non-zero, otherwise the register would sit at zero forever.
module lfsr8_galois
  import memory_game_pkg::*;
#(
  parameter logic [7:0] INIT_VAL = 8'h01
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_seed,
  input  logic       i_step,
  output logic [7:0] o_value
);

  logic [7:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= INIT_VAL;
    end else if (i_load) begin
      r_value <= (i_seed == 8'h00) ? INIT_VAL : i_seed;
    end else if (i_step) begin
      r_value <= lfsr8_next(r_value);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/board_shuffle_ctrl.sv
// rtl/board_shuffle_ctrl.sv - port-B arbiter and board fill/shuffle sequencer for the card memory
//
// Ports:
//   Clk        design clock
//   Reset_bar  asynchronous active-low reset; aborts any operation without Done
//   Seed       shuffle seed, sampled when Start is accepted
//   Start      one-cycle request to initialise the board (accepted only in IDLE)
//   Busy       high while the sequencer owns the RAM port
//   Done       one-cycle pulse after the last write
//   Gp_grant   high while gameplay owns the port
//   gp         gameplay port-B requests (slave side); gp.dout is a copy of mem.dout
//   mem        RAM port B (master side)
// Parameters:
//   SWAP_PASSES  full shuffle passes over addresses 15..0 (1..4)
//   LFSR_INIT    LFSR reset value and substitute for a zero Seed
// Build option:
//   BOARD_SHUFFLE_EN  defined: fill then LFSR shuffle; undefined: ordered fill only
module board_shuffle_ctrl
  import memory_game_pkg::*;
#(
  parameter int unsigned SWAP_PASSES = 1,
  parameter logic [7:0]  LFSR_INIT   = 8'h01
) (
  input  logic                 Clk,
  input  logic                 Reset_bar,
  input  logic [7:0]           Seed,
  input  logic                 Start,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Gp_grant,
  board_shuffle_ctrl_if.slave  gp,
  board_shuffle_ctrl_if.master mem
);

  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(NUM_CARDS - 1);

  shuffle_state_t    r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_fill_k;
  logic              w_start_acc;

  assign w_start_acc = (r_state == IDLE) && Start;

`ifdef BOARD_SHUFFLE_EN
  localparam logic [1:0] PASS_LAST = 2'(SWAP_PASSES - 1);

  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [1:0]        r_pass;
  logic [3:0]        r_val_i;
  logic [3:0]        r_val_j;
  logic [7:0]        w_lfsr;
  logic [3:0]        w_unused_lfsr_hi;

  lfsr8_galois #(
    .INIT_VAL (LFSR_INIT)
  ) u_lfsr (
    .i_clk   (Clk),
    .i_rst_n (Reset_bar),
    .i_load  (w_start_acc),
    .i_seed  (Seed),
    .i_step  (r_state == WR_J),
    .o_value (w_lfsr)
  );

  assign w_unused_lfsr_hi = w_lfsr[7:4];
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{Seed, LFSR_INIT, 3'(SWAP_PASSES)};
`endif

  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fill_k <= '0;
`ifdef BOARD_SHUFFLE_EN
      r_i      <= '0;
      r_j      <= '0;
      r_pass   <= '0;
      r_val_i  <= '0;
      r_val_j  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state  <= FILL;
            r_busy   <= 1'b1;
            r_fill_k <= '0;
          end
        end
        FILL: begin
          r_fill_k <= r_fill_k + 1'b1;
          if (r_fill_k == FILL_LAST) begin
`ifdef BOARD_SHUFFLE_EN
            r_state <= RD_I;
            r_i     <= FILL_LAST;
            r_pass  <= '0;
`else
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef BOARD_SHUFFLE_EN
        RD_I: begin
          r_j     <= w_lfsr[ADDR_W-1:0];
          r_state <= RD_J;
        end
        // RAM read latency is one cycle: data for address i lands here.
        RD_J: begin
          r_val_i <= mem.dout[3:0];
          r_state <= CAP;
        end
        CAP: begin
          r_val_j <= mem.dout[3:0];
          r_state <= WR_I;
        end
        WR_I: begin
          r_state <= WR_J;
        end
        WR_J: begin
          r_i <= r_i - 1'b1;
          if (r_i == '0 && r_pass == PASS_LAST) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            if (r_i == '0) begin
              r_pass <= r_pass + 1'b1;
            end
            r_state <= RD_I;
          end
        end
`endif
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Gameplay passes straight through whenever the sequencer is not busy;
  // an accepted Start suppresses a same-cycle gameplay write.
  always_comb begin
    mem.we   = 1'b0;
    mem.addr = gp.addr;
    mem.din  = gp.din;
    if (!r_busy) begin
      mem.we = gp.we & ~w_start_acc & Reset_bar;
    end else begin
      case (r_state)
        FILL: begin
          mem.we   = 1'b1;
          mem.addr = r_fill_k;
          mem.din  = face_down_card({1'b0, r_fill_k[3:1]});
        end
`ifdef BOARD_SHUFFLE_EN
        RD_I: begin
          mem.addr = r_i;
        end
        RD_J, CAP: begin
          mem.addr = r_j;
        end
        WR_I: begin
          mem.we   = 1'b1;
          mem.addr = r_i;
          mem.din  = face_down_card(r_val_j);
        end
        WR_J: begin
          mem.we   = 1'b1;
          mem.addr = r_j;
          mem.din  = face_down_card(r_val_i);
        end
`endif
        default: begin
          mem.we = 1'b0;
        end
      endcase
    end
  end

  assign gp.dout  = mem.dout;
  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Gp_grant = ~r_busy;

endmodule

// File: tb/tb_board_shuffle_ctrl.sv
// tb/tb_board_shuffle_ctrl.sv - randomized self-checking bench for board_shuffle_ctrl
module tb_board_shuffle_ctrl;

  localparam int TB_PASSES = 1;
`ifdef BOARD_SHUFFLE_EN
  localparam int DONE_CYC    = 16 + 80 * TB_PASSES + 1;
  localparam int GPW_CYC     = 40;
  localparam int RESTART_CYC = 50;
  localparam int ABORT_CYC   = 30;
`else
  localparam int DONE_CYC    = 17;
  localparam int GPW_CYC     = 8;
  localparam int RESTART_CYC = 10;
  localparam int ABORT_CYC   = 10;
`endif

  logic       Clk = 1'b0;
  logic       Reset_bar;
  logic [7:0] Seed;
  logic       Start;
  logic       Busy;
  logic       Done;
  logic       Gp_grant;

  board_shuffle_ctrl_if gp_bus();
  board_shuffle_ctrl_if mem_bus();

  board_shuffle_ctrl #(
    .SWAP_PASSES (TB_PASSES),
    .LFSR_INIT   (8'h01)
  ) dut (
    .Clk       (Clk),
    .Reset_bar (Reset_bar),
    .Seed      (Seed),
    .Start     (Start),
    .Busy      (Busy),
    .Done      (Done),
    .Gp_grant  (Gp_grant),
    .gp        (gp_bus),
    .mem       (mem_bus)
  );

  always #5 Clk = ~Clk;

  // Card RAM port B: synchronous write, registered read (old data on collision).
  logic [5:0] ram [16];
  always @(posedge Clk) begin
    if (mem_bus.we) ram[mem_bus.addr] <= mem_bus.din;
    mem_bus.dout <= ram[mem_bus.addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] shadow    [16];
  logic [5:0] exp_board [16];
  logic [5:0] img_seed1 [16];
  int         sw_i      [64];
  int         sw_j      [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Reference board: pairs laid out in order, then Fisher-Yates-like swaps of
  // i (15 down to 0) with the low nibble of a Galois LFSR sequence.
  task automatic build_expected(input logic [7:0] seed);
    int         l;
    int         j;
    logic [5:0] t;
    for (int a = 0; a < 16; a++) exp_board[a] = 6'h10 + 6'(a / 2);
    l = (seed == 8'h00) ? 1 : int'(seed);
`ifdef BOARD_SHUFFLE_EN
    for (int p = 0; p < TB_PASSES; p++) begin
      for (int i = 15; i >= 0; i--) begin
        j = l % 16;
        sw_i[p * 16 + (15 - i)] = i;
        sw_j[p * 16 + (15 - i)] = j;
        t            = exp_board[i];
        exp_board[i] = exp_board[j];
        exp_board[j] = t;
        l = (l / 2) ^ ((l % 2 == 1) ? 184 : 0);
      end
    end
`else
    sw_i[0] = l;
    sw_j[0] = l;
`endif
  endtask

  task automatic gp_write_check(input logic [3:0] a, input logic [5:0] d);
    gp_bus.we   = 1'b1;
    gp_bus.addr = a;
    gp_bus.din  = d;
    #1;
    check_eq("pt_we", mem_bus.we, 1'b1);
    check_eq("pt_addr", mem_bus.addr, a);
    check_eq("pt_din", mem_bus.din, d);
    shadow[a] = d;
    step();
    gp_bus.we = 1'b0;
  endtask

  task automatic idle_traffic(input int n_ops);
    bit         w;
    bit         pend;
    logic [3:0] a;
    logic [5:0] d;
    logic [5:0] pend_val;
    pend     = 1'b0;
    pend_val = '0;
    for (int k = 0; k < n_ops; k++) begin
      w = ($urandom_range(0, 1) == 1);
      a = 4'($urandom);
      d = 6'($urandom);
      gp_bus.we   = w;
      gp_bus.addr = a;
      gp_bus.din  = d;
      Start       = 1'b0;
      #1;
      if (pend) check_eq("gp_dout", gp_bus.dout, pend_val);
      check_eq("pt_we", mem_bus.we, w);
      check_eq("pt_addr", mem_bus.addr, a);
      if (w) check_eq("pt_din", mem_bus.din, d);
      check_eq("grant_idle", Gp_grant, 1'b1);
      pend     = !w;
      pend_val = shadow[a];
      if (w) shadow[a] = d;
      step();
    end
    gp_bus.we = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] seed, input int gpw_cyc, input int restart_cyc);
    bit         e_we;
    bit         e_chk_addr;
    bit         e_chk_din;
    logic [3:0] e_addr;
    logic [5:0] e_din;
    int         n;
    int         ph;
    build_expected(seed);
    Seed        = seed;
    Start       = 1'b1;
    gp_bus.we   = 1'b1;
    gp_bus.addr = 4'hA;
    gp_bus.din  = 6'h2A;
    #1;
    check_eq("start_wins", mem_bus.we, 1'b0);
    step();
    Seed = 8'($urandom);
    for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
      Start       = (cyc == restart_cyc);
      gp_bus.we   = (cyc == gpw_cyc);
      gp_bus.addr = 4'h0;
      gp_bus.din  = 6'h3F;
      #1;
      if (cyc < DONE_CYC) begin
        check_eq("busy", Busy, 1'b1);
        check_eq("done_early", Done, 1'b0);
        if (cyc == gpw_cyc) check_eq("grant_busy", Gp_grant, 1'b0);
        e_chk_addr = 1'b1;
        e_chk_din  = 1'b0;
        e_din      = '0;
        if (cyc <= 16) begin
          e_we      = 1'b1;
          e_addr    = 4'(cyc - 1);
          e_din     = 6'h10 + 6'((cyc - 1) / 2);
          e_chk_din = 1'b1;
        end else begin
          n          = (cyc - 17) / 5;
          ph         = (cyc - 17) % 5;
          e_we       = (ph >= 3);
          e_addr     = (ph == 0 || ph == 3) ? 4'(sw_i[n]) : 4'(sw_j[n]);
          e_chk_addr = (ph != 2);
        end
        check_eq("mem_we", mem_bus.we, e_we);
        if (e_chk_addr) check_eq("mem_addr", mem_bus.addr, e_addr);
        if (e_chk_din) check_eq("mem_din", mem_bus.din, e_din);
      end else begin
        check_eq("done_cycle", Done, 1'b1);
        check_eq("busy_drop", Busy, 1'b0);
      end
      step();
    end
    Start     = 1'b0;
    gp_bus.we = 1'b0;
    #1;
    check_eq("done_one_cycle", Done, 1'b0);
    check_eq("busy_after", Busy, 1'b0);
    for (int a = 0; a < 16; a++) begin
      check_eq($sformatf("ram_%0d", a), ram[a], exp_board[a]);
      shadow[a] = exp_board[a];
    end
  endtask

  task automatic check_board_shape();
    int cnt [8];
    foreach (cnt[v]) cnt[v] = 0;
    for (int a = 0; a < 16; a++) begin
      check_eq("word_flags", ram[a][5:3], 3'b010);
      cnt[ram[a][2:0]]++;
    end
    foreach (cnt[v]) check_eq($sformatf("pair_count_%0d", v), cnt[v], 2);
  endtask

  task automatic abort_op(input logic [7:0] seed);
    int dones;
    int busys;
    Seed      = seed;
    Start     = 1'b1;
    gp_bus.we = 1'b0;
    step();
    Start = 1'b0;
    for (int c = 1; c < ABORT_CYC; c++) step();
    check_eq("busy_before_abort", Busy, 1'b1);
    Reset_bar   = 1'b0;
    gp_bus.we   = 1'b1;
    gp_bus.addr = 4'h6;
    gp_bus.din  = 6'h11;
    #1;
    check_eq("abort_busy", Busy, 1'b0);
    check_eq("abort_done", Done, 1'b0);
    check_eq("abort_grant", Gp_grant, 1'b1);
    check_eq("abort_mem_we", mem_bus.we, 1'b0);
    check_eq("abort_mem_addr", mem_bus.addr, 4'h6);
    step();
    step();
    Reset_bar = 1'b1;
    gp_bus.we = 1'b0;
    dones     = 0;
    busys     = 0;
    for (int c = 0; c < DONE_CYC + 20; c++) begin
      #1;
      if (Done) dones++;
      if (Busy) busys++;
      step();
    end
    check_eq("abort_no_done", dones, 0);
    check_eq("abort_stays_idle", busys, 0);
  endtask

  initial begin
    Reset_bar   = 1'b0;
    Start       = 1'b0;
    Seed        = 8'h00;
    gp_bus.we   = 1'b1;
    gp_bus.addr = 4'h3;
    gp_bus.din  = 6'h15;
    repeat (2) @(posedge Clk);
    #2;
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_done", Done, 1'b0);
    check_eq("rst_grant", Gp_grant, 1'b1);
    check_eq("rst_mem_we", mem_bus.we, 1'b0);
    check_eq("rst_mem_addr", mem_bus.addr, 4'h3);
    check_eq("rst_mem_din", mem_bus.din, 6'h15);
    step();
    Reset_bar = 1'b1;
    gp_bus.we = 1'b0;
    step();

    for (int a = 0; a < 16; a++) gp_write_check(4'(a), 6'($urandom));

    gp_write_check(4'h5, 6'h23);
    gp_bus.addr = 4'h5;
    step();
    check_eq("read_back_5", gp_bus.dout, 6'h23);

    idle_traffic(40);

    run_op(8'h01, GPW_CYC, RESTART_CYC);
    check_board_shape();
    foreach (img_seed1[a]) img_seed1[a] = ram[a];

    idle_traffic(30);

    run_op(8'h00, 0, 0);
    check_board_shape();
    for (int a = 0; a < 16; a++) check_eq($sformatf("seed0_vs_seed1_%0d", a), ram[a], img_seed1[a]);

    abort_op(8'($urandom));

    run_op(8'($urandom), GPW_CYC, RESTART_CYC);
    check_board_shape();
    idle_traffic(30);
    run_op(8'($urandom_range(1, 255)), 0, 0);
    check_board_shape();
    idle_traffic(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
